// File: rtl/memory_arbiter.sv
// Two-master arbiter: fetch (imem) and load/store (dmem) share one memory port.
// Define ARBITER_FAIR_EN to bound how long dmem priority can starve imem.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state, state_next;
  logic   grant_i, grant_d;
  logic   force_i;

`ifdef ARBITER_FAIR_EN
  logic [2:0] starve_cnt;

  assign force_i = imem_valid && dmem_valid && (starve_cnt == 3'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst)                        starve_cnt <= '0;
    else if (grant_i)               starve_cnt <= '0;
    else if (grant_d && imem_valid) starve_cnt <= starve_cnt + 3'd1;
  end
`else
  // Strict dmem priority: the limit never applies, so imem is never forced.
  assign force_i = (STARVE_LIMIT < 0);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (dmem_valid && !force_i) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (imem_valid) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (mem_ready) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        mem_valid <= 1'b1;
        mem_instr <= dmem_instr;
        mem_addr  <= dmem_addr;
        mem_wdata <= dmem_wdata;
        mem_wstrb <= dmem_wstrb;
      end else if (grant_i) begin
        mem_valid <= 1'b1;
        mem_instr <= imem_instr;
        mem_addr  <= imem_addr;
        mem_wdata <= imem_wdata;
        mem_wstrb <= imem_wstrb;
      end else if (state != IDLE && mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end

  // Responses are combinational from mem_ready; the idle side always sees zeros.
  assign imem_ready = !rst && (state == BUSY_I) && mem_ready;
  assign dmem_ready = !rst && (state == BUSY_D) && mem_ready;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;
  assign busy       = (state != IDLE);

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst (1 = reset, sampled only on the clk rising edge).
REQ-002 clk  in  1  core clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 imem_valid, imem_instr, imem_addr, imem_wdata, imem_wstrb  in  1,1,32,32,4  fetch-side request; wstrb 0 means read.
REQ-005 imem_rdata, imem_ready  out  32,1  fetch-side response.
REQ-006 dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb  in  1,1,32,32,4  load/store-side request.
REQ-007 dmem_rdata, dmem_ready  out  32,1  load/store-side response.
REQ-008 mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb  out  1,1,32,32,4  shared memory port request.
REQ-009 mem_rdata, mem_ready  in  32,1  shared memory port response.
REQ-010 busy  out  1  a transaction is outstanding (state is not IDLE).
REQ-011 Parameter STARVE_LIMIT, default 4, meaning: maximum consecutive dmem grants while imem waits (fair mode only).

Function
REQ-012 The FSM SHALL have states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE with dmem_valid=1, the FSM SHALL capture the dmem request fields into output registers and go to BUSY_D at the next edge; fair override is defined in REQ-026.
REQ-014 In IDLE with only imem_valid=1, the FSM SHALL capture the imem fields and go to BUSY_I.
REQ-015 In IDLE with no valid request, the FSM SHALL stay in IDLE with mem_valid=0.
REQ-016 mem_valid SHALL be registered, asserted in BUSY_I/BUSY_D, and held with stable addr/wdata/wstrb/instr until mem_ready=1.
REQ-017 Latency SHALL be one cycle from a request in IDLE to mem_valid=1.
REQ-018 In BUSY_x with mem_ready=1, the block SHALL combinationally drive x_ready=1 and x_rdata=mem_rdata in that same cycle, and return to IDLE at the next edge.
REQ-019 The non-granted side SHALL see ready=0 and rdata=0 at all times.
REQ-020 After completion, IDLE SHALL always last at least one cycle, so a requester's held valid on the completion cycle is never re-granted.
REQ-021 A requester SHALL hold valid until its ready is seen; dropping valid before grant is legal and is ignored without error.
REQ-022 Request fields that change while a requester is waiting SHALL be sampled only at grant.
REQ-023 mem_ready in IDLE SHALL be ignored, with both ready outputs at 0.
REQ-024 A write (wstrb≠0) SHALL still pulse ready, with rdata passed through as don't-care.

Reset
REQ-025 With rst=1 at an edge, the block SHALL set state=IDLE, mem_valid=0, mem_addr/wdata/wstrb/instr=0, busy=0, starvation counter=0, and hold imem_ready=dmem_ready=0 while in reset; a transaction in flight is abandoned and any later mem_ready is ignored per REQ-023.

Configuration
REQ-026 With macro ARBITER_FAIR_EN defined, a 3-bit starvation counter SHALL:
- increment on each dmem grant while imem_valid=1;
- clear on each imem grant;
- when equal to STARVE_LIMIT with both valid in IDLE, force an imem grant.
REQ-027 Without ARBITER_FAIR_EN, the counter SHALL be absent and dmem SHALL have strict priority.

Verification
REQ-028 The bench SHALL cover these scenarios:
- imem_valid=1, addr=0x100, mem_ready after 3 cycles, rdata=0xDEADBEEF -> mem_valid at cycle 1; imem_ready=1 and imem_rdata=0xDEADBEEF on cycle 4; busy 1 during cycles 1-4.
- imem and dmem valid together in IDLE, dmem addr=0x2000 -> mem_addr=0x2000; imem granted after dmem completes plus one IDLE cycle.
- dmem store, addr=0x40, wdata=0x12345678, wstrb=4'b0011 -> mem outputs match exactly and stay stable over 5 wait cycles.
- ARBITER_FAIR_EN, STARVE_LIMIT=4, both valid continuously -> grant order D,D,D,D,I repeating; without the macro -> D only.
- rst pulsed in BUSY_D before mem_ready -> next cycle mem_valid=0, busy=0; a late mem_ready produces no ready pulse.
- mem_ready asserted in IDLE with rdata=0xFFFFFFFF -> imem_ready=dmem_ready=0 and both rdata=0.
